// File: rtl/adder_share_arbiter.sv
// Round-robin front end sharing one 6-bit add/sub datapath between two requesters.
// Optional feature: define ADDER_OVF_COUNT_EN to build the saturating overflow counter.

module six_bit_ripple_adder (
    input  logic [5:0] x,
    input  logic [5:0] y,
    input  logic       sel,
    output logic [5:0] sum,
    output logic       c_out,
    output logic       ovf
);

    logic carry;
    logic c5;
    logic yb;

    // sel=1 turns the adder into x + ~y + 1; c5 is the carry into the sign bit
    always_comb begin
        carry = sel;
        c5    = 1'b0;
        yb    = 1'b0;
        sum   = '0;
        for (int i = 0; i < 6; i++) begin
            yb     = y[i] ^ sel;
            sum[i] = x[i] ^ yb ^ carry;
            if (i == 5) c5 = carry;
            carry  = (x[i] & yb) | (carry & (x[i] ^ yb));
        end
        c_out = carry;
        ovf   = c5 ^ carry;
    end

endmodule

module adder_share_arbiter #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [5:0] req0_x,
    input  logic [5:0] req0_y,
    input  logic       req0_sub,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [5:0] req1_x,
    input  logic [5:0] req1_y,
    input  logic       req1_sub,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [5:0] rsp_sum,
    output logic       rsp_cout,
    output logic       rsp_ovf,
    output logic [7:0] ovf_count
);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t     state;
    state_t     state_next;
    logic       last_grant;
    logic       grant_any;
    logic       grant_id;
    logic [5:0] op_x;
    logic [5:0] op_y;
    logic       op_sub;
    logic       op_id;
    logic [5:0] add_sum;
    logic       add_cout;
    logic       add_ovf;

    six_bit_ripple_adder u_adder (
        .x     (op_x),
        .y     (op_y),
        .sel   (op_sub),
        .sum   (add_sum),
        .c_out (add_cout),
        .ovf   (add_ovf)
    );

    // Grant decision is only made in IDLE; a tie goes to whoever was not served last
    always_comb begin
        state_next = state;
        grant_any  = 1'b0;
        grant_id   = 1'b0;
        case (state)
            IDLE: begin
                if (!reset) begin
                    if (req0_valid && req1_valid) begin
                        grant_any = 1'b1;
                        grant_id  = ~last_grant;
                    end else if (req0_valid) begin
                        grant_any = 1'b1;
                        grant_id  = 1'b0;
                    end else if (req1_valid) begin
                        grant_any = 1'b1;
                        grant_id  = 1'b1;
                    end
                end
                if (grant_any) state_next = CALC;
            end
            CALC: state_next = RESP;
            RESP: begin
                if (rsp_valid && rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        req0_ready = grant_any & ~grant_id;
        req1_ready = grant_any & grant_id;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= ~RR_INIT;
            op_x       <= '0;
            op_y       <= '0;
            op_sub     <= 1'b0;
            op_id      <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_sum    <= '0;
            rsp_cout   <= 1'b0;
            rsp_ovf    <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && grant_any) begin
                op_x       <= grant_id ? req1_x : req0_x;
                op_y       <= grant_id ? req1_y : req0_y;
                op_sub     <= grant_id ? req1_sub : req0_sub;
                op_id      <= grant_id;
                last_grant <= grant_id;
            end
            if (state == CALC) begin
                rsp_valid <= 1'b1;
                rsp_id    <= op_id;
                rsp_sum   <= add_sum;
                rsp_cout  <= add_cout;
                rsp_ovf   <= add_ovf;
            end
            if (state == RESP && rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ADDER_OVF_COUNT_EN
    logic [7:0] ovf_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_cnt <= 8'h00;
        end else if (rsp_valid && rsp_ready && rsp_ovf && ovf_cnt != 8'hFF) begin
            ovf_cnt <= ovf_cnt + 8'h01;
        end
    end

    assign ovf_count = ovf_cnt;
`else
    assign ovf_count = 8'h00;
`endif

endmodule
